// File: rtl/mem_arbiter.sv
// Arbitrates icache fills and dcache loads/stores onto one word-wide RAM port.
// Dcache wins by default; a saturating starvation counter forces an icache grant.
module mem_arbiter #(
    parameter int WORD_W     = 32,
    parameter int STARVE_MAX = 4
) (
    input  logic              CLK,
    input  logic              RST,
    input  logic              iREN,
    input  logic [WORD_W-1:0] iaddr,
    output logic              iwait,
    output logic [WORD_W-1:0] iload,
    input  logic              dREN,
    input  logic              dWEN,
    input  logic [WORD_W-1:0] daddr,
    input  logic [WORD_W-1:0] dstore,
    output logic              dwait,
    output logic [WORD_W-1:0] dload,
    output logic              ramREN,
    output logic              ramWEN,
    output logic [WORD_W-1:0] ramaddr,
    output logic [WORD_W-1:0] ramstore,
    input  logic [WORD_W-1:0] ramload,
    input  logic              ramready
);

    typedef enum logic [1:0] {
        IDLE,
        DBUSY,
        IBUSY
    } state_t;

    state_t     state;
    state_t     state_next;
    logic [3:0] starve_cnt;
    logic [3:0] starve_next;
    logic       d_req;
    logic       starved;
    logic       grant_d;
    logic       grant_i;

    assign d_req   = dREN | dWEN;
    assign starved = iREN && (starve_cnt == 4'(STARVE_MAX));
    assign iload   = ramload;
    assign dload   = ramload;

    always_comb begin
        state_next  = state;
        starve_next = starve_cnt;
        grant_d     = 1'b0;
        grant_i     = 1'b0;
        iwait       = 1'b1;
        dwait       = 1'b1;
        case (state)
            IDLE: begin
                if (d_req && !starved) begin
                    grant_d    = 1'b1;
                    state_next = DBUSY;
                end else if (iREN) begin
                    grant_i    = 1'b1;
                    state_next = IBUSY;
                end
                if (!iREN || grant_i) begin
                    starve_next = 4'd0;
                end else if (grant_d && (starve_cnt != 4'hF)) begin
                    starve_next = starve_cnt + 4'd1;
                end
            end
            // A withdrawn request ends the transaction silently, even if RAM is ready.
            DBUSY: begin
                if (!d_req) begin
                    state_next = IDLE;
                end else if (ramready) begin
                    dwait      = 1'b0;
                    state_next = IDLE;
                end
            end
            IBUSY: begin
                if (!iREN) begin
                    state_next = IDLE;
                end else if (ramready) begin
                    iwait      = 1'b0;
                    state_next = IDLE;
                end
            end
            default: state_next = IDLE;
        endcase
        if (RST) begin
            iwait = 1'b1;
            dwait = 1'b1;
        end
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            state      <= IDLE;
            starve_cnt <= 4'd0;
            ramREN     <= 1'b0;
            ramWEN     <= 1'b0;
            ramaddr    <= '0;
            ramstore   <= '0;
        end else begin
            state      <= state_next;
            starve_cnt <= starve_next;
            if (grant_d) begin
                ramaddr  <= daddr;
                ramstore <= dstore;
                ramWEN   <= dWEN;
                ramREN   <= dREN & ~dWEN;
            end else if (grant_i) begin
                ramaddr <= iaddr;
                ramREN  <= 1'b1;
                ramWEN  <= 1'b0;
            end else if (state_next == IDLE) begin
                ramREN <= 1'b0;
                ramWEN <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_mem_arbiter.sv
// Self-checking bench for mem_arbiter: directed vector table, corner-case sequences,
// and randomized traffic compared every cycle against a transaction-level reference model.
module tb_mem_arbiter;

    localparam int WORD_W     = 32;
    localparam int STARVE_MAX = 4;

    logic              CLK = 1'b0;
    logic              RST = 1'b1;
    logic              iREN = 1'b0;
    logic [WORD_W-1:0] iaddr = '0;
    logic              iwait;
    logic [WORD_W-1:0] iload;
    logic              dREN = 1'b0;
    logic              dWEN = 1'b0;
    logic [WORD_W-1:0] daddr = '0;
    logic [WORD_W-1:0] dstore = '0;
    logic              dwait;
    logic [WORD_W-1:0] dload;
    logic              ramREN;
    logic              ramWEN;
    logic [WORD_W-1:0] ramaddr;
    logic [WORD_W-1:0] ramstore;
    logic [WORD_W-1:0] ramload = '0;
    logic              ramready = 1'b0;

    int checks = 0;
    int errors = 0;

    mem_arbiter #(.WORD_W(WORD_W), .STARVE_MAX(STARVE_MAX)) dut (
        .CLK(CLK), .RST(RST),
        .iREN(iREN), .iaddr(iaddr), .iwait(iwait), .iload(iload),
        .dREN(dREN), .dWEN(dWEN), .daddr(daddr), .dstore(dstore),
        .dwait(dwait), .dload(dload),
        .ramREN(ramREN), .ramWEN(ramWEN), .ramaddr(ramaddr), .ramstore(ramstore),
        .ramload(ramload), .ramready(ramready)
    );

    always #5 CLK = ~CLK;

    typedef struct {
        logic        rst;
        logic        iren;
        logic        dren;
        logic        dwen;
        logic [31:0] iaddr;
        logic [31:0] daddr;
        logic [31:0] dstore;
        logic [31:0] ramload;
        logic        ready;
    } stim_t;

    typedef struct {
        stim_t       s;
        logic        e_iwait;
        logic        e_dwait;
        logic        e_ren;
        logic        e_wen;
        logic [31:0] e_addr;
        logic [31:0] e_store;
    } vec_t;

    task automatic checkOutput(input string name, input logic [31:0] actual,
                               input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("[TB] FAIL %s actual=%h expected=%h at %0t", name, actual, expected, $time);
        end
    endtask

    // Inputs change just after the rising edge; outputs are sampled on the falling edge.
    task automatic applyStimulus(input stim_t s);
        @(posedge CLK);
        #1;
        RST      = s.rst;
        iREN     = s.iren;
        dREN     = s.dren;
        dWEN     = s.dwen;
        iaddr    = s.iaddr;
        daddr    = s.daddr;
        dstore   = s.dstore;
        ramload  = s.ramload;
        ramready = s.ready;
    endtask

    function automatic stim_t mkStim(logic rst, logic iren, logic dren, logic dwen,
                                     logic [31:0] ia, logic [31:0] da, logic [31:0] ds,
                                     logic [31:0] ld, logic rdy);
        stim_t s;
        s.rst = rst; s.iren = iren; s.dren = dren; s.dwen = dwen;
        s.iaddr = ia; s.daddr = da; s.dstore = ds; s.ramload = ld; s.ready = rdy;
        return s;
    endfunction

    function automatic vec_t mkVec(stim_t s, logic eiw, logic edw, logic eren, logic ewen,
                                   logic [31:0] eaddr, logic [31:0] estore);
        vec_t v;
        v.s = s; v.e_iwait = eiw; v.e_dwait = edw; v.e_ren = eren; v.e_wen = ewen;
        v.e_addr = eaddr; v.e_store = estore;
        return v;
    endfunction

    // Reference model: tracks the current owner and its latched transaction,
    // plus the count of consecutive dcache grants taken while icache waited.
    int          m_owner = 0;
    logic        m_read = 1'b0;
    logic        m_write = 1'b0;
    logic [31:0] m_addr = '0;
    logic [31:0] m_store = '0;
    int          m_streak = 0;

    always @(negedge CLK) begin
        logic e_iw;
        logic e_dw;
        e_iw = 1'b1;
        e_dw = 1'b1;
        if (!RST) begin
            if (m_owner == 1 && (dREN || dWEN) && ramready) e_dw = 1'b0;
            if (m_owner == 2 && iREN && ramready) e_iw = 1'b0;
        end
        checkOutput("model_iwait", 32'(iwait), 32'(e_iw));
        checkOutput("model_dwait", 32'(dwait), 32'(e_dw));
        checkOutput("model_ramREN", 32'(ramREN), 32'(m_owner != 0 && m_read));
        checkOutput("model_ramWEN", 32'(ramWEN), 32'(m_owner != 0 && m_write));
        checkOutput("model_ramaddr", ramaddr, m_addr);
        checkOutput("model_ramstore", ramstore, m_store);
        checkOutput("model_iload", iload, ramload);
        checkOutput("model_dload", dload, ramload);

        if (RST) begin
            m_owner  <= 0;
            m_read   <= 1'b0;
            m_write  <= 1'b0;
            m_addr   <= '0;
            m_store  <= '0;
            m_streak <= 0;
        end else if (m_owner == 1) begin
            if (!(dREN || dWEN) || ramready) m_owner <= 0;
        end else if (m_owner == 2) begin
            if (!iREN || ramready) m_owner <= 0;
        end else if ((dREN || dWEN) && !(iREN && m_streak == STARVE_MAX)) begin
            m_owner  <= 1;
            m_addr   <= daddr;
            m_store  <= dstore;
            m_write  <= dWEN;
            m_read   <= !dWEN;
            m_streak <= iREN ? ((m_streak < 15) ? m_streak + 1 : 15) : 0;
        end else if (iREN) begin
            m_owner  <= 2;
            m_addr   <= iaddr;
            m_read   <= 1'b1;
            m_write  <= 1'b0;
            m_streak <= 0;
        end else begin
            m_streak <= 0;
        end
    end

    vec_t  tbl[14];
    byte   order[$];
    string pattern;
    stim_t s;

    initial begin
        // Reset with both requests high, single fetch with 3-cycle RAM, then write/fetch collision.
        tbl[0]  = mkVec(mkStim(1,1,1,0,32'h40,32'h20,0,0,0),                       1,1,0,0,32'h0,  32'h0);
        tbl[1]  = mkVec(mkStim(1,1,1,0,32'h40,32'h20,0,0,0),                       1,1,0,0,32'h0,  32'h0);
        tbl[2]  = mkVec(mkStim(0,1,1,0,32'h40,32'h20,0,32'hA1,0),                  1,1,0,0,32'h0,  32'h0);
        tbl[3]  = mkVec(mkStim(0,1,1,0,32'h40,32'h20,0,32'hCAFE0001,1),            1,0,1,0,32'h20, 32'h0);
        tbl[4]  = mkVec(mkStim(0,1,0,0,32'h40,32'h20,0,0,0),                       1,1,0,0,32'h20, 32'h0);
        tbl[5]  = mkVec(mkStim(0,1,0,0,32'h40,32'h20,0,0,0),                       1,1,1,0,32'h40, 32'h0);
        tbl[6]  = mkVec(mkStim(0,1,0,0,32'h40,32'h20,0,0,0),                       1,1,1,0,32'h40, 32'h0);
        tbl[7]  = mkVec(mkStim(0,1,0,0,32'h40,32'h20,0,0,0),                       1,1,1,0,32'h40, 32'h0);
        tbl[8]  = mkVec(mkStim(0,1,0,0,32'h40,32'h20,0,32'hDEADBEEF,1),            0,1,1,0,32'h40, 32'h0);
        tbl[9]  = mkVec(mkStim(0,1,0,1,32'h40,32'h100,32'h12345678,0,0),          1,1,0,0,32'h40, 32'h0);
        tbl[10] = mkVec(mkStim(0,1,0,1,32'h40,32'h100,32'h12345678,32'h55AA,1),   1,0,0,1,32'h100,32'h12345678);
        tbl[11] = mkVec(mkStim(0,1,0,0,32'h40,32'h100,32'h12345678,0,0),          1,1,0,0,32'h100,32'h12345678);
        tbl[12] = mkVec(mkStim(0,1,0,0,32'h40,32'h100,32'h12345678,32'h0BAD,1),   0,1,1,0,32'h40, 32'h12345678);
        tbl[13] = mkVec(mkStim(0,0,0,0,32'h40,32'h100,32'h12345678,0,0),          1,1,0,0,32'h40, 32'h12345678);

        for (int i = 0; i < 14; i++) begin
            applyStimulus(tbl[i].s);
            @(negedge CLK);
            checkOutput($sformatf("vec%0d_iwait", i), 32'(iwait), 32'(tbl[i].e_iwait));
            checkOutput($sformatf("vec%0d_dwait", i), 32'(dwait), 32'(tbl[i].e_dwait));
            checkOutput($sformatf("vec%0d_ramREN", i), 32'(ramREN), 32'(tbl[i].e_ren));
            checkOutput($sformatf("vec%0d_ramWEN", i), 32'(ramWEN), 32'(tbl[i].e_wen));
            checkOutput($sformatf("vec%0d_ramaddr", i), ramaddr, tbl[i].e_addr);
            checkOutput($sformatf("vec%0d_ramstore", i), ramstore, tbl[i].e_store);
            checkOutput($sformatf("vec%0d_iload", i), iload, tbl[i].s.ramload);
        end

        // Starvation: dREN and iREN held with zero-wait RAM; every fifth grant goes to icache.
        applyStimulus(mkStim(1,1,1,0,32'h44,32'h88,0,32'h77,1));
        for (int k = 0; k < 20; k++) begin
            applyStimulus(mkStim(0,1,1,0,32'h44,32'h88,0,32'h77 + k,1));
            @(negedge CLK);
            if (!dwait) order.push_back("D");
            if (!iwait) order.push_back("I");
        end
        pattern = "DDDDIDDDDI";
        checkOutput("starve_count", 32'(order.size()), 32'd10);
        for (int k = 0; k < 10; k++) begin
            checkOutput($sformatf("starve_order%0d", k), 32'(order[k]), 32'(pattern[k]));
        end

        // Abort: dREN withdrawn two cycles into DBUSY while RAM becomes ready.
        applyStimulus(mkStim(1,0,0,0,0,0,0,0,0));
        applyStimulus(mkStim(0,1,1,0,32'h44,32'h80,0,0,0));
        applyStimulus(mkStim(0,1,1,0,32'h44,32'h80,0,0,0));
        @(negedge CLK);
        checkOutput("abort_busy_ren", 32'(ramREN), 32'd1);
        checkOutput("abort_busy_addr", ramaddr, 32'h80);
        applyStimulus(mkStim(0,1,1,0,32'h44,32'h80,0,0,0));
        applyStimulus(mkStim(0,1,0,0,32'h44,32'h80,0,32'h99,1));
        @(negedge CLK);
        checkOutput("abort_dwait", 32'(dwait), 32'd1);
        applyStimulus(mkStim(0,1,0,0,32'h44,32'h80,0,0,0));
        @(negedge CLK);
        checkOutput("abort_idle_ren", 32'(ramREN), 32'd0);
        checkOutput("abort_idle_dwait", 32'(dwait), 32'd1);
        applyStimulus(mkStim(0,1,0,0,32'h44,32'h80,0,0,0));
        @(negedge CLK);
        checkOutput("abort_igrant_ren", 32'(ramREN), 32'd1);
        checkOutput("abort_igrant_addr", ramaddr, 32'h44);

        // Reset arriving during IBUSY together with ramready.
        applyStimulus(mkStim(1,0,0,0,0,0,0,0,0));
        applyStimulus(mkStim(0,1,0,0,32'h60,0,0,0,0));
        applyStimulus(mkStim(0,1,0,0,32'h60,0,0,0,0));
        @(negedge CLK);
        checkOutput("rstmid_busy_ren", 32'(ramREN), 32'd1);
        applyStimulus(mkStim(1,1,0,0,32'h60,0,0,32'h1234,1));
        @(negedge CLK);
        checkOutput("rstmid_iwait", 32'(iwait), 32'd1);
        applyStimulus(mkStim(0,0,0,0,32'h60,0,0,0,0));
        @(negedge CLK);
        checkOutput("rstmid_ren", 32'(ramREN), 32'd0);
        checkOutput("rstmid_addr", ramaddr, 32'h0);
        checkOutput("rstmid_after_iwait", 32'(iwait), 32'd1);

        // Randomized traffic; the reference model checks every cycle.
        for (int k = 0; k < 1500; k++) begin
            s.rst     = ($urandom_range(49) == 0);
            s.iren    = ($urandom_range(9) < 6);
            s.dren    = ($urandom_range(9) < 4);
            s.dwen    = ($urandom_range(9) < 3);
            s.iaddr   = $urandom();
            s.daddr   = $urandom();
            s.dstore  = $urandom();
            s.ramload = $urandom();
            s.ready   = ($urandom_range(9) < 4);
            applyStimulus(s);
        end
        @(negedge CLK);
        @(negedge CLK);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
